// File: rtl/seq_divider_pkg.sv
// Shared types and sizing constants for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DEF_DW = 16;
  localparam int DEF_VW = 8;

  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_DW);

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: conditional subtract of the divisor from a
// VW+1-bit partial remainder, yielding the next remainder and a quotient bit.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   pr,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_next,
  output logic          qbit
);

  logic [VW-1:0] diff;

  always_comb begin
    qbit = (pr >= {1'b0, divisor});
    // When the subtract is taken the true difference is < divisor, so the
    // low VW bits of the modular difference are exact.
    diff     = pr[VW-1:0] - divisor;
    rem_next = qbit ? diff : pr[VW-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: DW-bit dividend by VW-bit divisor, one
// quotient bit per clock, MSB first, with divide-by-zero short-circuit.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          dbz
);

  localparam int CW = cnt_width(DW);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd_r;
  logic [VW-1:0] dvs_r;
  logic [VW:0]   pr;
  logic [VW-1:0] rem_next;
  logic          qbit;

  // The remainder output doubles as the working partial remainder.
  assign pr = {remainder, dvd_r[DW-1]};

  div_step #(.VW(VW)) u_step (
    .pr       (pr),
    .divisor  (dvs_r),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      cnt       <= '0;
      dvd_r     <= '0;
      dvs_r     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          remainder <= rem_next;
          quotient  <= {quotient[DW-2:0], qbit};
          dvd_r     <= {dvd_r[DW-2:0], 1'b0};
          cnt       <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend[VW-1:0];
              dbz       <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              dvd_r     <= dividend;
              dvs_r     <= divisor;
              quotient  <= '0;
              remainder <= '0;
              dbz       <= 1'b0;
              cnt       <= CW'(DW);
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against a plain-arithmetic reference.
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        dbz;

  int unsigned nchecks = 0;
  int unsigned nerrors = 0;

  seq_divider #(.DW(16), .VW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called and returns at #1 after a rising edge. Issues one start with a/b,
  // scrambles operand inputs afterwards, optionally re-pulses start at RUN
  // cycle poke_at, then checks latency, busy span, results and done width.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input int poke_at,
                        input string tag);
    int unsigned   lat;
    int unsigned   nbusy;
    logic [15:0]   eq;
    logic [7:0]    er;
    logic [15:0]   a_copy;
    a_copy = a;
    if (b == 8'd0) begin
      eq = 16'hFFFF;
      er = a_copy[7:0];
    end else begin
      eq = a / 16'(b);
      er = 8'(a % 16'(b));
    end
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    lat = 0; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      start    = (poke_at >= 0 && lat == 32'(poke_at));
      dividend = 16'($urandom);
      divisor  = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, ".latency"}, lat, (b == 8'd0) ? 0 : 16);
    check({tag, ".busycycles"}, nbusy, (b == 8'd0) ? 0 : 16);
    check({tag, ".busy_at_done"}, 32'(busy), 0);
    check({tag, ".quotient"}, 32'(quotient), 32'(eq));
    check({tag, ".remainder"}, 32'(remainder), 32'(er));
    check({tag, ".dbz"}, 32'(dbz), (b == 8'd0) ? 1 : 0);
    @(posedge clk); #1;
    check({tag, ".done_width"}, 32'(done), 0);
    check({tag, ".q_held"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    int unsigned ndone;
    int          tlast;
    int          t;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset.quotient", 32'(quotient), 0);
    check("reset.remainder", 32'(remainder), 0);
    check("reset.flags", {29'd0, busy, done, dbz}, 0);
    check("reset.state", 32'(dut.state), 32'(IDLE));

    do_div(16'd1000, 8'd7, -1, "d1000_7");
    do_div(16'hFFFF, 8'h01, -1, "ffff_1");
    do_div(16'hFFFF, 8'hFF, -1, "ffff_ff");
    do_div(16'd5, 8'd10, -1, "d5_10");
    do_div(16'h1234, 8'h00, -1, "dbz");

    // start pulse with new operands during RUN must be ignored
    do_div(16'd1000, 8'd7, 5, "ignore_start");
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("ignore_start.no_extra_done", ndone, 0);

    // reset in the middle of a division
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset.outputs", {quotient, remainder, 5'd0, busy, done, dbz}, 0);
    check("midreset.state", 32'(dut.state), 32'(IDLE));
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midreset.no_done", ndone, 0);
    do_div(16'd200, 8'd9, -1, "after_reset");

    // start held high: back-to-back divisions every DW+1 cycles
    start = 1'b1; dividend = 16'd300; divisor = 8'd17;
    ndone = 0; tlast = -1;
    for (int c = 0; c < 80 && ndone < 4; c++) begin
      @(posedge clk); #1;
      t = c;
      if (done) begin
        ndone++;
        check("held.quotient", 32'(quotient), 17);
        check("held.remainder", 32'(remainder), 11);
        if (tlast >= 0) check("held.period", 32'(t - tlast), 17);
        tlast = t;
      end
    end
    start = 1'b0;
    check("held.pulses", ndone, 4);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      do_div(ra, rb, -1, "random");
    end

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
